// File: rtl/corner_sorter.sv
// corner_sorter: orders four unordered corner points into TL, TR, BR, BL.
// A captured quad is scanned one point per cycle to find the min-sum
// (TL) and max-sum (BR) points and to range-check every point. The two
// remaining points are split on x-y into TR and BL. The result or an
// error pulse appears in the cycle after the sixth edge following capture.
module corner_sorter #(
    parameter logic [9:0] H_MAX = 10'd1023,
    parameter logic [9:0] V_MAX = 10'd767
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        corners_done,
    input  logic [79:0] corners_in,
    output logic        busy,
    output logic        sorted_valid,
    output logic [79:0] corners_out,
    output logic        error
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SCAN    = 2'd1,
        S_RESOLVE = 2'd2,
        S_EMIT    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [79:0]         r_quad;
    logic [1:0]          r_idx;
    logic                r_bad;
    logic [1:0]          r_min_idx;
    logic [1:0]          r_max_idx;
    logic [10:0]         r_min_sum;
    logic [10:0]         r_max_sum;

    logic [1:0]          r_tr_idx;
    logic [1:0]          r_bl_idx;
    logic                r_quad_ok;

    logic                r_busy;
    logic                r_sorted_valid;
    logic                r_error;
    logic [79:0]         r_corners_out;

    logic [9:0]          w_scan_x;
    logic [9:0]          w_scan_y;
    logic [10:0]         w_scan_sum;
    logic                w_scan_oor;

    logic                w_found;
    logic [1:0]          w_rest_a;
    logic [1:0]          w_rest_b;
    logic signed [10:0]  w_d_a;
    logic signed [10:0]  w_d_b;
    logic [1:0]          w_tr_idx;
    logic [1:0]          w_bl_idx;
    logic [79:0]         w_sorted;

    // x coordinate of point i in a packed quad
    function automatic logic [9:0] pt_x(input logic [79:0] q, input logic [1:0] i);
        case (i)
            2'd0:    pt_x = q[79:70];
            2'd1:    pt_x = q[59:50];
            2'd2:    pt_x = q[39:30];
            default: pt_x = q[19:10];
        endcase
    endfunction

    // y coordinate of point i in a packed quad
    function automatic logic [9:0] pt_y(input logic [79:0] q, input logic [1:0] i);
        case (i)
            2'd0:    pt_y = q[69:60];
            2'd1:    pt_y = q[49:40];
            2'd2:    pt_y = q[29:20];
            default: pt_y = q[9:0];
        endcase
    endfunction

    // zero-extended 11-bit sum, wide enough for 1023+1023
    function automatic logic [10:0] sum11(input logic [9:0] x, input logic [9:0] y);
        sum11 = {1'b0, x} + {1'b0, y};
    endfunction

    // 11-bit two's-complement x-y, covers -1023..+1023 exactly
    function automatic logic signed [10:0] diff11(input logic [9:0] x, input logic [9:0] y);
        diff11 = $signed({1'b0, x}) - $signed({1'b0, y});
    endfunction

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // next-state logic: capture only from IDLE, fixed 4-cycle scan
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (corners_done) w_next_state = S_SCAN;
            S_SCAN:    if (r_idx == 2'd3) w_next_state = S_RESOLVE;
            S_RESOLVE: w_next_state = S_EMIT;
            S_EMIT:    w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // point under scan this cycle, its sum and range check
    always_comb begin
        w_scan_x   = pt_x(r_quad, r_idx);
        w_scan_y   = pt_y(r_quad, r_idx);
        w_scan_sum = sum11(w_scan_x, w_scan_y);
        // compared at 11 bits so the default H_MAX is not a full-range constant
        w_scan_oor = ({1'b0, w_scan_x} > {1'b0, H_MAX}) ||
                     ({1'b0, w_scan_y} > {1'b0, V_MAX});
    end

    // capture and scan: latch the quad, track min/max sum with lowest index on ties
    always_ff @(posedge clk) begin
        if (reset) begin
            r_quad    <= 80'd0;
            r_idx     <= 2'd0;
            r_bad     <= 1'b0;
            r_min_idx <= 2'd0;
            r_max_idx <= 2'd0;
            r_min_sum <= 11'd0;
            r_max_sum <= 11'd0;
        end else if (r_state == S_IDLE) begin
            if (corners_done) begin
                r_quad <= corners_in;
                r_idx  <= 2'd0;
                r_bad  <= 1'b0;
            end
        end else if (r_state == S_SCAN) begin
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd0) begin
                r_bad     <= w_scan_oor;
                r_min_idx <= 2'd0;
                r_max_idx <= 2'd0;
                r_min_sum <= w_scan_sum;
                r_max_sum <= w_scan_sum;
            end else begin
                r_bad <= r_bad | w_scan_oor;
                if (w_scan_sum < r_min_sum) begin
                    r_min_idx <= r_idx;
                    r_min_sum <= w_scan_sum;
                end
                if (w_scan_sum > r_max_sum) begin
                    r_max_idx <= r_idx;
                    r_max_sum <= w_scan_sum;
                end
            end
        end
    end

    // pick the two leftover points in index order and split them on x-y
    always_comb begin
        w_found  = 1'b0;
        w_rest_a = 2'd0;
        w_rest_b = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if ((2'(i) != r_min_idx) && (2'(i) != r_max_idx)) begin
                if (!w_found) begin
                    w_rest_a = 2'(i);
                    w_found  = 1'b1;
                end else begin
                    w_rest_b = 2'(i);
                end
            end
        end
        w_d_a = diff11(pt_x(r_quad, w_rest_a), pt_y(r_quad, w_rest_a));
        w_d_b = diff11(pt_x(r_quad, w_rest_b), pt_y(r_quad, w_rest_b));
        // w_rest_a has the lower index, so it wins a tie
        if (w_d_a >= w_d_b) begin
            w_tr_idx = w_rest_a;
            w_bl_idx = w_rest_b;
        end else begin
            w_tr_idx = w_rest_b;
            w_bl_idx = w_rest_a;
        end
    end

    // resolve: freeze the TR/BL choice and the validity verdict
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tr_idx  <= 2'd0;
            r_bl_idx  <= 2'd0;
            r_quad_ok <= 1'b0;
        end else if (r_state == S_RESOLVE) begin
            r_tr_idx  <= w_tr_idx;
            r_bl_idx  <= w_bl_idx;
            r_quad_ok <= !r_bad && (r_min_idx != r_max_idx);
        end
    end

    // ordered quad assembled from the resolved indices
    always_comb begin
        w_sorted = {pt_x(r_quad, r_min_idx), pt_y(r_quad, r_min_idx),
                    pt_x(r_quad, r_tr_idx),  pt_y(r_quad, r_tr_idx),
                    pt_x(r_quad, r_max_idx), pt_y(r_quad, r_max_idx),
                    pt_x(r_quad, r_bl_idx),  pt_y(r_quad, r_bl_idx)};
    end

    // output registers: busy trails the FSM by one edge, result pulses leave EMIT
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy         <= 1'b0;
            r_sorted_valid <= 1'b0;
            r_error        <= 1'b0;
            r_corners_out  <= 80'd0;
        end else begin
            r_busy         <= (r_state != S_IDLE);
            r_sorted_valid <= 1'b0;
            r_error        <= 1'b0;
            if (r_state == S_EMIT) begin
                if (r_quad_ok) begin
                    r_corners_out  <= w_sorted;
                    r_sorted_valid <= 1'b1;
                end else begin
                    r_error <= 1'b1;
                end
            end
        end
    end

    assign busy         = r_busy;
    assign sorted_valid = r_sorted_valid;
    assign error        = r_error;
    assign corners_out  = r_corners_out;

endmodule

// File: tb/tb_corner_sorter.sv
// tb_corner_sorter: directed quads against an in-bench reference that
// sorts each captured quad with plain integer arithmetic, compared on
// every cycle, plus hand-computed literal results for each scenario.
module tb_corner_sorter;

    localparam int HM = 1023;
    localparam int VM = 767;

    logic        clk = 1'b0;
    logic        reset;
    logic        corners_done;
    logic [79:0] corners_in;
    logic        busy;
    logic        sorted_valid;
    logic [79:0] corners_out;
    logic        error;

    int vectors    = 0;
    int miscompares = 0;

    // reference state
    bit          chk_en   = 1'b0;
    bit          m_active = 1'b0;
    int          m_age    = 0;
    logic [79:0] m_q      = '0;
    logic [79:0] m_out    = '0;
    bit          m_busy   = 1'b0;
    bit          m_sv     = 1'b0;
    bit          m_err    = 1'b0;

    always #5 clk = ~clk;

    corner_sorter dut (
        .clk          (clk),
        .reset        (reset),
        .corners_done (corners_done),
        .corners_in   (corners_in),
        .busy         (busy),
        .sorted_valid (sorted_valid),
        .corners_out  (corners_out),
        .error        (error)
    );

    // returns 1 and the ordered quad when the quad is acceptable
    function automatic bit ref_sort(input logic [79:0] q, output logic [79:0] o);
        int x[4];
        int y[4];
        int s[4];
        int d[4];
        int rest[$];
        int tl;
        int br;
        int tr;
        int bl;
        bit bad;
        bad = 1'b0;
        o   = '0;
        for (int i = 0; i < 4; i++) begin
            x[i] = int'(q[79 - 20*i -: 10]);
            y[i] = int'(q[69 - 20*i -: 10]);
            s[i] = x[i] + y[i];
            d[i] = x[i] - y[i];
            if (x[i] > HM || y[i] > VM) bad = 1'b1;
        end
        tl = 0;
        br = 0;
        for (int i = 1; i < 4; i++) begin
            if (s[i] < s[tl]) tl = i;
            if (s[i] > s[br]) br = i;
        end
        if (bad || tl == br) return 1'b0;
        for (int i = 0; i < 4; i++)
            if (i != tl && i != br) rest.push_back(i);
        if (d[rest[0]] >= d[rest[1]]) begin
            tr = rest[0];
            bl = rest[1];
        end else begin
            tr = rest[1];
            bl = rest[0];
        end
        o = {10'(x[tl]), 10'(y[tl]), 10'(x[tr]), 10'(y[tr]),
             10'(x[br]), 10'(y[br]), 10'(x[bl]), 10'(y[bl])};
        return 1'b1;
    endfunction

    // reference timeline: result six edges after capture, new capture only when idle
    always @(posedge clk) begin
        logic [79:0] tmp;
        if (reset) begin
            m_active = 1'b0;
            m_busy   = 1'b0;
            m_sv     = 1'b0;
            m_err    = 1'b0;
            m_out    = '0;
        end else begin
            m_sv  = 1'b0;
            m_err = 1'b0;
            if (m_active) begin
                m_busy = 1'b1;
                m_age  = m_age + 1;
                if (m_age == 6) begin
                    m_active = 1'b0;
                    if (ref_sort(m_q, tmp)) begin
                        m_sv  = 1'b1;
                        m_out = tmp;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end else begin
                m_busy = 1'b0;
                if (corners_done) begin
                    m_active = 1'b1;
                    m_age    = 0;
                    m_q      = corners_in;
                end
            end
        end
    end

    // per-cycle compare against the reference
    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (sorted_valid !== m_sv || error !== m_err || busy !== m_busy ||
                corners_out !== m_out) begin
                miscompares++;
                $display("FAIL cycle t=%0t: got sv=%b err=%b busy=%b out=%h, need sv=%b err=%b busy=%b out=%h",
                         $time, sorted_valid, error, busy, corners_out, m_sv, m_err, m_busy, m_out);
            end
        end
    end

    task automatic check1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, need %b", name, act, exp);
        end
    endtask

    task automatic check80(input string name, input logic [79:0] act, input logic [79:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, need %h", name, act, exp);
        end
    endtask

    // one-cycle corners_done pulse; returns 2 time units after the capture edge
    task automatic send(input logic [79:0] q);
        @(posedge clk);
        #2;
        corners_in   = q;
        corners_done = 1'b1;
        @(posedge clk);
        #2;
        corners_done = 1'b0;
    endtask

    // from 2 units after the capture edge to 2 units after the sixth edge
    task automatic to_slot();
        repeat (6) @(posedge clk);
        #2;
    endtask

    logic [79:0] q_axis;
    logic [79:0] q_rot;
    logic [79:0] q_bad_y;
    logic [79:0] q_same;
    logic [79:0] q_edge;
    logic [79:0] q_dtie;
    logic [79:0] e_axis;
    logic [79:0] e_rot;
    logic [79:0] e_edge;
    logic [79:0] e_dtie;

    initial begin
        q_axis  = {10'd192, 10'd144, 10'd192, 10'd624, 10'd832, 10'd624, 10'd832, 10'd144};
        e_axis  = {10'd192, 10'd144, 10'd832, 10'd144, 10'd832, 10'd624, 10'd192, 10'd624};
        // sums 600,1300,1300,600: ties go to the lower index, so (900,400) is BR
        // and (600,700) with the larger x-y is TR
        q_rot   = {10'd500, 10'd100, 10'd900, 10'd400, 10'd600, 10'd700, 10'd200, 10'd400};
        e_rot   = {10'd500, 10'd100, 10'd600, 10'd700, 10'd900, 10'd400, 10'd200, 10'd400};
        q_bad_y = {10'd100, 10'd100, 10'd700, 10'd100, 10'd700, 10'd800, 10'd100, 10'd600};
        q_same  = {10'd300, 10'd300, 10'd300, 10'd300, 10'd300, 10'd300, 10'd300, 10'd300};
        q_edge  = {10'd0, 10'd0, 10'd1023, 10'd0, 10'd1023, 10'd767, 10'd0, 10'd767};
        e_edge  = {10'd0, 10'd0, 10'd1023, 10'd0, 10'd1023, 10'd767, 10'd0, 10'd767};
        // every x-y is 0: points 0 and 2 remain, lower index 0 becomes TR
        q_dtie  = {10'd100, 10'd100, 10'd300, 10'd300, 10'd200, 10'd200, 10'd50, 10'd50};
        e_dtie  = {10'd50, 10'd50, 10'd100, 10'd100, 10'd300, 10'd300, 10'd200, 10'd200};

        reset        = 1'b1;
        corners_done = 1'b1;
        corners_in   = q_axis;
        repeat (3) @(posedge clk);
        #2;
        check1("reset busy", busy, 1'b0);
        check1("reset sv", sorted_valid, 1'b0);
        check1("reset err", error, 1'b0);
        check80("reset out", corners_out, 80'd0);
        corners_done = 1'b0;
        reset        = 1'b0;
        chk_en       = 1'b1;

        // axis-aligned rectangle
        send(q_axis);
        check1("axis busy E0", busy, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        check1("axis sv early", sorted_valid, 1'b0);
        check1("axis busy E5", busy, 1'b1);
        @(posedge clk);
        #2;
        check1("axis sv", sorted_valid, 1'b1);
        check1("axis err", error, 1'b0);
        check80("axis out", corners_out, e_axis);
        @(posedge clk);
        #2;
        check1("axis sv drop", sorted_valid, 1'b0);
        check1("axis busy drop", busy, 1'b0);

        // rotated quad with sum ties
        send(q_rot);
        to_slot();
        check1("rot sv", sorted_valid, 1'b1);
        check1("rot err", error, 1'b0);
        check80("rot out", corners_out, e_rot);

        // y out of range
        send(q_bad_y);
        to_slot();
        check1("bady err", error, 1'b1);
        check1("bady sv", sorted_valid, 1'b0);
        check80("bady out held", corners_out, e_rot);

        // degenerate: all points identical
        send(q_same);
        to_slot();
        check1("same err", error, 1'b1);
        check1("same sv", sorted_valid, 1'b0);

        // coordinate limits, largest sum 1790
        send(q_edge);
        to_slot();
        check1("edge sv", sorted_valid, 1'b1);
        check80("edge out", corners_out, e_edge);

        // x-y tie between the leftover points
        send(q_dtie);
        to_slot();
        check1("dtie sv", sorted_valid, 1'b1);
        check80("dtie out", corners_out, e_dtie);

        // second corners_done two cycles after the first is dropped
        send(q_axis);
        @(posedge clk);
        #2;
        corners_in   = q_rot;
        corners_done = 1'b1;
        @(posedge clk);
        #2;
        corners_done = 1'b0;
        check1("overlap busy", busy, 1'b1);
        repeat (4) @(posedge clk);
        #2;
        check1("overlap sv", sorted_valid, 1'b1);
        check80("overlap out", corners_out, e_axis);
        repeat (8) @(posedge clk);
        #2;
        check80("overlap no second", corners_out, e_axis);

        // reset during the third scan cycle aborts the operation
        send(q_rot);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        check1("abort busy", busy, 1'b0);
        check80("abort out", corners_out, 80'd0);
        repeat (8) @(posedge clk);
        #2;
        check1("abort sv", sorted_valid, 1'b0);
        check80("abort out later", corners_out, 80'd0);
        send(q_rot);
        to_slot();
        check1("after abort sv", sorted_valid, 1'b1);
        check80("after abort out", corners_out, e_rot);

        repeat (3) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
